// File: rtl/vending_machine_multi.sv
// vending_machine_multi
//   Multi-item vending controller. It tracks the stock of each item, accepts
//   coins of several values, and limits the balance to MAX_BAL. A cancel
//   refunds the balance. Change is returned serially, one hopper pulse per
//   CHANGE_UNIT.
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   coin_valid/coin_type  : coin strobe; type 0..3 -> 5, 10, 25, 50 units
//   sel_valid/sel_idx     : item selection strobe
//   cancel                : refund request strobe
//   restock_valid/_idx    : refill one item to MAX_STOCK (honoured in any state)
//   item_dispense         : 1-cycle dispense pulse, dispense_idx valid with it
//   change_out            : one pulse per CHANGE_UNIT returned
//   coin_reject           : coin not credited (1 cycle)
//   sold_out              : selection refused, stock empty or index out of range
//   insufficient          : selection refused, balance below price
//   busy                  : FSM not idle
//   balance               : current credit
//   empty                 : bit i set when item i has zero stock
//
// Every output is a flop or a decode of the state register, so no
// combinational path runs from an input to an output.
module vending_machine_multi #(
    parameter int N_ITEMS     = 4,
    parameter int BAL_W       = 8,
    parameter int MAX_BAL     = 200,
    parameter int PRICE_BASE  = 10,
    parameter int PRICE_STEP  = 5,
    parameter int CHANGE_UNIT = 5,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 5,
    localparam int SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel_idx,
    input  logic               cancel,
    input  logic               restock_valid,
    input  logic [SEL_W-1:0]   restock_idx,
    output logic               item_dispense,
    output logic [SEL_W-1:0]   dispense_idx,
    output logic               change_out,
    output logic               coin_reject,
    output logic               sold_out,
    output logic               insufficient,
    output logic               busy,
    output logic [BAL_W-1:0]   balance,
    output logic [N_ITEMS-1:0] empty
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    localparam logic [STOCK_W-1:0] MAX_STOCK  = '1;
    localparam logic [STOCK_W-1:0] INIT_STK   = STOCK_W'(INIT_STOCK);
    localparam logic [BAL_W:0]     MAX_BAL_X  = (BAL_W+1)'(MAX_BAL);
    localparam logic [BAL_W-1:0]   CU         = BAL_W'(CHANGE_UNIT);

    logic [1:0]         state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [STOCK_W-1:0] stock_q [N_ITEMS];
    logic [STOCK_W-1:0] stock_d [N_ITEMS];
    logic [SEL_W-1:0]   dispense_idx_q, dispense_idx_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sold_out_q, sold_out_d;
    logic               insufficient_q, insufficient_d;

    logic [BAL_W:0]     coin_val;
    logic [BAL_W:0]     coin_sum;
    logic               sel_in_range;
    logic [STOCK_W-1:0] sel_stock;
    logic [BAL_W:0]     sel_price;
    logic               dec_en;

    always_comb begin
        coin_val = '0;
        case (coin_type)
            2'd0:    coin_val = (BAL_W+1)'(5);
            2'd1:    coin_val = (BAL_W+1)'(10);
            2'd2:    coin_val = (BAL_W+1)'(25);
            default: coin_val = (BAL_W+1)'(50);
        endcase
    end

    // One extra bit on the sum so an overflowing coin is caught rather than wrapped.
    assign coin_sum     = {1'b0, balance_q} + coin_val;
    assign sel_in_range = (int'(sel_idx) < N_ITEMS);
    assign sel_stock    = sel_in_range ? stock_q[sel_idx] : '0;
    assign sel_price    = (BAL_W+1)'(PRICE_BASE + int'(sel_idx) * PRICE_STEP);

    always_comb begin
        state_d        = state_q;
        balance_d      = balance_q;
        dispense_idx_d = dispense_idx_q;
        coin_reject_d  = 1'b0;
        sold_out_d     = 1'b0;
        insufficient_d = 1'b0;
        dec_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    // A coin that arrives with cancel is refused, even if
                    // the cancel itself has no effect.
                    coin_reject_d = coin_valid;
                    if (balance_q != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (!sel_in_range || sel_stock == '0) begin
                        sold_out_d = 1'b1;
                    end else if ({1'b0, balance_q} < sel_price) begin
                        insufficient_d = 1'b1;
                    end else begin
                        balance_d      = balance_q - sel_price[BAL_W-1:0];
                        dec_en         = 1'b1;
                        dispense_idx_d = sel_idx;
                        state_d        = ST_VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_sum > MAX_BAL_X) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        balance_d = coin_sum[BAL_W-1:0];
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                state_d       = (balance_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                // The balance is always a multiple of CU. So the last pulse is
                // the cycle where the balance holds exactly one unit.
                if (balance_q <= CU) begin
                    balance_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    balance_d = balance_q - CU;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stock next-state. A restock is applied after the decrement, so a
    // restock of the item being vended in the same cycle takes priority.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (dec_en && int'(sel_idx) == i) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
            if (restock_valid && int'(restock_idx) == i) begin
                stock_d[i] = MAX_STOCK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            balance_q      <= '0;
            dispense_idx_q <= '0;
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b0;
            insufficient_q <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= INIT_STK;
            end
        end else begin
            state_q        <= state_d;
            balance_q      <= balance_d;
            dispense_idx_q <= dispense_idx_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
            insufficient_q <= insufficient_d;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_empty
        assign empty[gi] = (stock_q[gi] == '0);
    end

    assign item_dispense = (state_q == ST_VEND);
    assign change_out    = (state_q == ST_CHANGE);
    assign busy          = (state_q != ST_IDLE);
    assign dispense_idx  = dispense_idx_q;
    assign coin_reject   = coin_reject_q;
    assign sold_out      = sold_out_q;
    assign insufficient  = insufficient_q;
    assign balance       = balance_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Testbench for vending_machine_multi. It has a scoreboard with one queue of
// expected pulse cycles per pulse output. The driver pushes expectations from
// a transaction-level model. The monitor pops them and compares them as the
// DUT pulses.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       cancel;
    logic       restock_valid;
    logic [1:0] restock_idx;
    logic       item_dispense;
    logic [1:0] dispense_idx;
    logic       change_out;
    logic       coin_reject;
    logic       sold_out;
    logic       insufficient;
    logic       busy;
    logic [7:0] balance;
    logic [3:0] empty;

    always #5 clk = ~clk;

    vending_machine_multi dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .item_dispense (item_dispense),
        .dispense_idx  (dispense_idx),
        .change_out    (change_out),
        .coin_reject   (coin_reject),
        .sold_out      (sold_out),
        .insufficient  (insufficient),
        .busy          (busy),
        .balance       (balance),
        .empty         (empty)
    );

    localparam int K_DISP = 0;
    localparam int K_CHG  = 1;
    localparam int K_REJ  = 2;
    localparam int K_SOLD = 3;
    localparam int K_INS  = 4;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state, at the level of credit and stock counts.
    int bal_m = 0;
    int stock_m [4];
    int busy_last = -1;   // last cycle in which the machine is busy
    int vend_cyc  = -1;   // cycle of the dispense for the current vend
    bit mon_en = 1'b0;

    int qs [5][$];        // expected pulse cycles, one queue per output
    int q_didx [$];       // expected dispense_idx, parallel to qs[K_DISP]

    function automatic int cval(input logic [1:0] t);
        case (t)
            2'd0:    return 5;
            2'd1:    return 10;
            2'd2:    return 25;
            default: return 50;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and update the model.
    task automatic step(input bit cv, input bit [1:0] ct, input bit sv, input bit [1:0] si,
                        input bit cn, input bit rv, input bit [1:0] ri, input bit rs);
        int c;
        int k;
        int price;
        @(negedge clk);
        c = cyc;
        reset = rs; coin_valid = cv; coin_type = ct; sel_valid = sv; sel_idx = si;
        cancel = cn; restock_valid = rv; restock_idx = ri;
        $display("cyc %0d: coin=%0b/%0d sel=%0b/%0d cancel=%0b restock=%0b/%0d reset=%0b",
                 c, cv, ct, sv, si, cn, rv, ri, rs);
        if (rs) begin
            // Discard every expectation that falls after the reset edge.
            for (int q = 0; q < 5; q++) begin
                while (qs[q].size() > 0 && qs[q][qs[q].size()-1] >= c + 1) begin
                    void'(qs[q].pop_back());
                    if (q == K_DISP) void'(q_didx.pop_back());
                end
            end
            bal_m = 0;
            for (int i = 0; i < 4; i++) stock_m[i] = 5;
            if (busy_last > c) busy_last = c;
        end else begin
            if (c <= busy_last) begin
                if (cv) qs[K_REJ].push_back(c + 1);
            end else if (cn) begin
                if (cv) qs[K_REJ].push_back(c + 1);
                if (bal_m > 0) begin
                    k = bal_m / 5;
                    for (int j = 1; j <= k; j++) qs[K_CHG].push_back(c + j);
                    busy_last = c + k;
                    vend_cyc  = -1;
                    bal_m     = 0;
                end
            end else if (sv) begin
                if (cv) qs[K_REJ].push_back(c + 1);
                price = 10 + 5 * int'(si);
                if (stock_m[si] == 0) begin
                    qs[K_SOLD].push_back(c + 1);
                end else if (bal_m < price) begin
                    qs[K_INS].push_back(c + 1);
                end else begin
                    bal_m = bal_m - price;
                    stock_m[si]--;
                    qs[K_DISP].push_back(c + 1);
                    q_didx.push_back(int'(si));
                    k = bal_m / 5;
                    for (int j = 0; j < k; j++) qs[K_CHG].push_back(c + 2 + j);
                    busy_last = c + 1 + k;
                    vend_cyc  = c + 1;
                    bal_m     = 0;
                end
            end else if (cv) begin
                if (bal_m + cval(ct) > 200) qs[K_REJ].push_back(c + 1);
                else bal_m = bal_m + cval(ct);
            end
            if (rv) stock_m[ri] = 15;
        end
    endtask

    task automatic idle1();
        step(0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 0);
    endtask
    task automatic coin(input bit [1:0] ct);
        step(1, ct, 0, 2'd0, 0, 0, 2'd0, 0);
    endtask
    task automatic sel(input bit [1:0] si);
        step(0, 2'd0, 1, si, 0, 0, 2'd0, 0);
    endtask
    task automatic do_cancel();
        step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0, 0);
    endtask
    task automatic wait_idle();
        int n = 0;
        while (cyc <= busy_last && n < 500) begin
            idle1();
            n++;
        end
        idle1();
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        logic p [5];
        string nm [5];
        int e;
        int di;
        int exp_bal;
        int exp_empty;
        nm[0] = "item_dispense"; nm[1] = "change_out"; nm[2] = "coin_reject";
        nm[3] = "sold_out"; nm[4] = "insufficient";
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                p[0] = item_dispense; p[1] = change_out; p[2] = coin_reject;
                p[3] = sold_out; p[4] = insufficient;
                for (int k = 0; k < 5; k++) begin
                    if (p[k] === 1'b1) begin
                        checks++;
                        if (qs[k].size() == 0) begin
                            errors++;
                            $display("FAIL %s: unexpected pulse at cycle %0d, required none", nm[k], cyc);
                        end else begin
                            e = qs[k].pop_front();
                            if (e != cyc) begin
                                errors++;
                                $display("FAIL %s: pulse at cycle %0d, required cycle %0d", nm[k], cyc, e);
                            end
                            if (k == K_DISP) begin
                                di = q_didx.pop_front();
                                chk("dispense_idx", int'(dispense_idx), di);
                            end
                        end
                    end else if (qs[k].size() > 0 && qs[k][0] <= cyc) begin
                        checks++;
                        errors++;
                        e = qs[k].pop_front();
                        if (k == K_DISP) void'(q_didx.pop_front());
                        $display("FAIL %s: no pulse at cycle %0d, required at cycle %0d", nm[k], cyc, e);
                    end
                end
                if (cyc <= busy_last)
                    exp_bal = (cyc == vend_cyc) ? (busy_last - cyc) * 5 : (busy_last - cyc + 1) * 5;
                else
                    exp_bal = bal_m;
                exp_empty = 0;
                for (int i = 0; i < 4; i++) if (stock_m[i] == 0) exp_empty |= (1 << i);
                chk("balance", int'(balance), exp_bal);
                chk("busy", int'(busy), (cyc <= busy_last) ? 1 : 0);
                chk("empty", int'(empty), exp_empty);
            end
        end
    end

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0;
        sel_idx = 2'd0; cancel = 1'b0; restock_valid = 1'b0; restock_idx = 2'd0;
        for (int i = 0; i < 4; i++) stock_m[i] = 5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        idle1();
        chk("reset_balance", int'(balance), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_empty", int'(empty), 0);
        chk("reset_pulses", int'({item_dispense, change_out, coin_reject, sold_out, insufficient}), 0);

        // 10 + 5, buy item 1 (price 15), exact change
        coin(2'd1); coin(2'd0); sel(2'd1); wait_idle();
        chk("exact_vend_balance", int'(balance), 0);

        // 50, buy item 0 (price 10): 8 change pulses
        coin(2'd3); sel(2'd0); wait_idle();
        chk("change_vend_busy", int'(busy), 0);

        // 5, select item 3 (price 25): insufficient, balance held
        coin(2'd0); sel(2'd3); idle1();
        chk("insufficient_balance", int'(balance), 5);
        do_cancel(); wait_idle();

        // Drain item 2, then sold out, then restock
        for (int n = 0; n < 5; n++) begin
            coin(2'd2); sel(2'd2); wait_idle();
        end
        coin(2'd2); sel(2'd2); idle1();
        chk("soldout_empty2", int'(empty[2]), 1);
        chk("soldout_balance", int'(balance), 25);
        do_cancel(); wait_idle();
        step(0, 2'd0, 0, 2'd0, 0, 1, 2'd2, 0); idle1();
        chk("restock_empty2", int'(empty[2]), 0);
        coin(2'd2); sel(2'd2); wait_idle();

        // Saturation at 200, then a coin colliding with a selection,
        // then a coin while change is paid out
        repeat (4) coin(2'd3);
        coin(2'd0); idle1();
        chk("saturated_balance", int'(balance), 200);
        step(1, 2'd0, 1, 2'd0, 0, 0, 2'd0, 0);
        repeat (4) idle1();
        coin(2'd1);
        wait_idle();

        // Cancel refund, then cancel interrupted by reset after 2 pulses
        coin(2'd2); do_cancel(); wait_idle();
        coin(2'd2); do_cancel(); idle1();
        step(0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 1);
        idle1(); idle1();
        chk("reset_abort_balance", int'(balance), 0);
        chk("reset_abort_busy", int'(busy), 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            bit cv, sv, cn, rv, rs;
            r  = int'($urandom_range(0, 99));
            rs = (r == 0);
            cv = ($urandom_range(0, 99) < 35);
            sv = ($urandom_range(0, 99) < 12);
            cn = ($urandom_range(0, 99) < 4);
            rv = ($urandom_range(0, 99) < 3);
            if (rs) step(0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 1);
            else step(cv, 2'($urandom_range(0, 3)), sv, 2'($urandom_range(0, 3)),
                      cn, rv, 2'($urandom_range(0, 3)), 0);
        end
        wait_idle();
        repeat (3) idle1();
        for (int k = 0; k < 5; k++) chk("leftover_expected", qs[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
